// File: rtl/ct_ifu_l0_btb_param_array_if.sv
// L0 BTB lookup/update/invalidate bundle.
// Master drives requests; slave returns lookup results and valid bits.
interface ct_ifu_l0_btb_param_array_if #(
  parameter int ENTRY_NUM = 16,
  parameter int TAG_W     = 15,
  parameter int TGT_W     = 20,
  parameter int WAY_W     = 2
);
  logic                 lkp_vld;
  logic [TAG_W-1:0]     lkp_tag;
  logic                 lkp_hit;
  logic [TGT_W-1:0]     lkp_target;
  logic [WAY_W-1:0]     lkp_way_pred;
  logic                 lkp_ras;
  logic                 lkp_taken;
  logic                 upd_vld;
  logic [TAG_W-1:0]     upd_tag;
  logic [TGT_W-1:0]     upd_target;
  logic [WAY_W-1:0]     upd_way_pred;
  logic                 upd_ras;
  logic                 upd_taken;
  logic                 inv;
  logic [ENTRY_NUM-1:0] entry_vld_vec;

  modport master (
    output lkp_vld, lkp_tag,
    output upd_vld, upd_tag, upd_target,
    output upd_way_pred, upd_ras, upd_taken,
    output inv,
    input  lkp_hit, lkp_target, lkp_way_pred,
    input  lkp_ras, lkp_taken, entry_vld_vec
  );

  modport slave (
    input  lkp_vld, lkp_tag,
    input  upd_vld, upd_tag, upd_target,
    input  upd_way_pred, upd_ras, upd_taken,
    input  inv,
    output lkp_hit, lkp_target, lkp_way_pred,
    output lkp_ras, lkp_taken, entry_vld_vec
  );
endinterface

// File: rtl/ct_ifu_l0_btb_param_array.sv
// Fully-associative L0 BTB: one-cycle registered lookup,
// counter-trained update, lowest-free / round-robin allocation.
module ct_ifu_l0_btb_param_array #(
  parameter int ENTRY_NUM = 16,
  parameter int TAG_W     = 15,
  parameter int TGT_W     = 20,
  parameter int WAY_W     = 2
) (
  input  logic forever_cpuclk,
  input  logic cpurst_b,
  input  logic cp0_ifu_btb_en,
  input  logic cp0_ifu_l0btb_en,
  ct_ifu_l0_btb_param_array_if.slave bus
);

  localparam int PTR_W = $clog2(ENTRY_NUM);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] tgt;
    logic [WAY_W-1:0] way;
    logic             ras;
    logic [1:0]       cnt;
  } entry_t;

  logic                 w_act;
  logic                 w_upd_go;
  logic                 w_upd_hit;
  logic                 w_alloc;
  logic                 w_has_free;
  logic [PTR_W-1:0]     w_free_idx;
  logic [PTR_W-1:0]     w_victim;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [ENTRY_NUM-1:0] w_lkp_vec;
  logic [ENTRY_NUM-1:0] w_upd_vec;
  logic [ENTRY_NUM-1:0] w_vld_vec;
  logic [ENTRY_NUM-1:0] w_ent_en;
  entry_t               w_ent [ENTRY_NUM];

  logic                 w_l_hit;
  logic [TGT_W-1:0]     w_l_tgt;
  logic [WAY_W-1:0]     w_l_way;
  logic                 w_l_ras;
  logic                 w_l_taken;

  logic                 r_lkp_hit;
  logic [TGT_W-1:0]     r_lkp_tgt;
  logic [WAY_W-1:0]     r_lkp_way;
  logic                 r_lkp_ras;
  logic                 r_lkp_taken;

  assign w_act     = cp0_ifu_btb_en & cp0_ifu_l0btb_en;
  assign w_upd_go  = bus.upd_vld & w_act & ~bus.inv;
  assign w_upd_hit = |w_upd_vec;
  assign w_alloc   = w_upd_go & ~w_upd_hit
                   & bus.upd_taken;

  // Descending scan so the lowest invalid index wins.
  always_comb begin
    w_free_idx = '0;
    w_has_free = 1'b0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!w_vld_vec[i]) begin
        w_free_idx = PTR_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  assign w_victim = w_has_free ? w_free_idx
                               : r_rr_ptr;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rr_ptr <= '0;
    end else if (bus.inv) begin
      r_rr_ptr <= '0;
    end else if (w_alloc && !w_has_free) begin
      r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end

  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_ent
    entry_t r_ent;

    assign w_ent[g]     = r_ent;
    assign w_vld_vec[g] = r_ent.vld;
    assign w_lkp_vec[g] = r_ent.vld
                        & (r_ent.tag == bus.lkp_tag);
    assign w_upd_vec[g] = r_ent.vld
                        & (r_ent.tag == bus.upd_tag);
    // Per-entry write enable doubles as the clock-gate enable.
    assign w_ent_en[g]  = bus.inv
                        | (w_upd_go & w_upd_vec[g])
                        | (w_alloc
                           & (w_victim == PTR_W'(g)));

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        r_ent <= '0;
      end else if (w_ent_en[g]) begin
        if (bus.inv) begin
          r_ent <= '0;
        end else if (w_upd_vec[g]) begin
          if (bus.upd_taken) begin
            r_ent.cnt <= (r_ent.cnt == 2'b11) ? 2'b11
                       : r_ent.cnt + 2'd1;
            r_ent.tgt <= bus.upd_target;
            r_ent.way <= bus.upd_way_pred;
            r_ent.ras <= bus.upd_ras;
          end else begin
            r_ent.cnt <= (r_ent.cnt == 2'b00) ? 2'b00
                       : r_ent.cnt - 2'd1;
          end
        end else begin
          r_ent.vld <= 1'b1;
          r_ent.tag <= bus.upd_tag;
          r_ent.tgt <= bus.upd_target;
          r_ent.way <= bus.upd_way_pred;
          r_ent.ras <= bus.upd_ras;
          r_ent.cnt <= 2'b10;
        end
      end
    end
  end

  // Tags are unique, so OR-merging the hit vector is a one-hot mux.
  always_comb begin
    w_l_hit   = 1'b0;
    w_l_tgt   = '0;
    w_l_way   = '0;
    w_l_ras   = 1'b0;
    w_l_taken = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (w_lkp_vec[i]) begin
        w_l_hit   = 1'b1;
        w_l_tgt   = w_l_tgt | w_ent[i].tgt;
        w_l_way   = w_l_way | w_ent[i].way;
        w_l_ras   = w_l_ras | w_ent[i].ras;
        w_l_taken = w_l_taken | w_ent[i].cnt[1];
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_lkp_hit   <= 1'b0;
      r_lkp_tgt   <= '0;
      r_lkp_way   <= '0;
      r_lkp_ras   <= 1'b0;
      r_lkp_taken <= 1'b0;
    end else if (bus.lkp_vld && w_act && w_l_hit) begin
      r_lkp_hit   <= 1'b1;
      r_lkp_tgt   <= w_l_tgt;
      r_lkp_way   <= w_l_way;
      r_lkp_ras   <= w_l_ras;
      r_lkp_taken <= w_l_taken;
    end else begin
      r_lkp_hit   <= 1'b0;
      r_lkp_tgt   <= '0;
      r_lkp_way   <= '0;
      r_lkp_ras   <= 1'b0;
      r_lkp_taken <= 1'b0;
    end
  end

  assign bus.lkp_hit       = r_lkp_hit;
  assign bus.lkp_target    = r_lkp_tgt;
  assign bus.lkp_way_pred  = r_lkp_way;
  assign bus.lkp_ras       = r_lkp_ras;
  assign bus.lkp_taken     = r_lkp_taken;
  assign bus.entry_vld_vec = w_vld_vec;

endmodule

// File: tb/tb_ct_ifu_l0_btb_param_array.sv
// Bench for the L0 BTB: directed scenarios plus random traffic,
// all checked against an array-based behavioural model.
module tb_ct_ifu_l0_btb_param_array;

  localparam int N = 16;

  logic clk;
  logic rst_n;
  logic btb_en;
  logic l0_en;

  ct_ifu_l0_btb_param_array_if #(
    .ENTRY_NUM(N), .TAG_W(15), .TGT_W(20), .WAY_W(2)
  ) bus ();

  ct_ifu_l0_btb_param_array #(
    .ENTRY_NUM(N), .TAG_W(15), .TGT_W(20), .WAY_W(2)
  ) dut (
    .forever_cpuclk  (clk),
    .cpurst_b        (rst_n),
    .cp0_ifu_btb_en  (btb_en),
    .cp0_ifu_l0btb_en(l0_en),
    .bus             (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  bit          m_vld [N];
  logic [14:0] m_tag [N];
  logic [19:0] m_tgt [N];
  logic [1:0]  m_way [N];
  bit          m_ras [N];
  int          m_cnt [N];
  int          m_rr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
      m_way[i] = '0; m_ras[i] = 0; m_cnt[i] = 0;
    end
    m_rr = 0;
  endtask

  function automatic logic [31:0] m_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_vld[i];
    return v;
  endfunction

  task automatic idle();
    bus.lkp_vld = 0; bus.lkp_tag = '0;
    bus.upd_vld = 0; bus.upd_tag = '0;
    bus.upd_target = '0; bus.upd_way_pred = '0;
    bus.upd_ras = 0; bus.upd_taken = 0;
    bus.inv = 0;
  endtask

  task automatic set_upd(input logic [14:0] t,
                         input logic [19:0] tg,
                         input bit tk);
    bus.upd_vld = 1; bus.upd_tag = t;
    bus.upd_target = tg; bus.upd_taken = tk;
    bus.upd_way_pred = tg[1:0]; bus.upd_ras = tg[2];
  endtask

  task automatic set_lkp(input logic [14:0] t);
    bus.lkp_vld = 1; bus.lkp_tag = t;
  endtask

  // One clock: predict from pre-edge model, advance model, compare.
  task automatic cyc();
    bit act;
    bit e_hit; logic [19:0] e_tgt; logic [1:0] e_way;
    bit e_ras; bit e_tk;
    int j;
    act = btb_en && l0_en;
    e_hit = 0; e_tgt = '0; e_way = '0; e_ras = 0; e_tk = 0;
    if (bus.lkp_vld && act)
      for (int i = 0; i < N; i++)
        if (m_vld[i] && m_tag[i] == bus.lkp_tag) begin
          e_hit = 1; e_tgt = m_tgt[i]; e_way = m_way[i];
          e_ras = m_ras[i]; e_tk = (m_cnt[i] >= 2);
        end
    if (bus.inv) begin
      m_clear();
    end else if (bus.upd_vld && act) begin
      j = -1;
      for (int i = 0; i < N; i++)
        if (m_vld[i] && m_tag[i] == bus.upd_tag) j = i;
      if (j >= 0) begin
        if (bus.upd_taken) begin
          m_cnt[j] = (m_cnt[j] < 3) ? m_cnt[j] + 1 : 3;
          m_tgt[j] = bus.upd_target;
          m_way[j] = bus.upd_way_pred;
          m_ras[j] = bus.upd_ras;
        end else begin
          m_cnt[j] = (m_cnt[j] > 0) ? m_cnt[j] - 1 : 0;
        end
      end else if (bus.upd_taken) begin
        for (int i = N - 1; i >= 0; i--)
          if (!m_vld[i]) j = i;
        if (j < 0) begin
          j = m_rr;
          m_rr = (m_rr + 1) % N;
        end
        m_vld[j] = 1; m_tag[j] = bus.upd_tag;
        m_tgt[j] = bus.upd_target;
        m_way[j] = bus.upd_way_pred;
        m_ras[j] = bus.upd_ras; m_cnt[j] = 2;
      end
    end
    @(posedge clk);
    #1;
    chk("hit", 32'(bus.lkp_hit), 32'(e_hit));
    chk("tgt", 32'(bus.lkp_target), 32'(e_tgt));
    chk("way", 32'(bus.lkp_way_pred), 32'(e_way));
    chk("ras", 32'(bus.lkp_ras), 32'(e_ras));
    chk("taken", 32'(bus.lkp_taken), 32'(e_tk));
    chk("vldvec", 32'(bus.entry_vld_vec), m_vec());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hit"}, 32'(bus.lkp_hit), 0);
    chk({tag, "_tgt"}, 32'(bus.lkp_target), 0);
    chk({tag, "_way"}, 32'(bus.lkp_way_pred), 0);
    chk({tag, "_ras"}, 32'(bus.lkp_ras), 0);
    chk({tag, "_tk"}, 32'(bus.lkp_taken), 0);
    chk({tag, "_vec"}, 32'(bus.entry_vld_vec), 0);
  endtask

  // Reset asserted mid-cycle with traffic in flight.
  task automatic do_reset();
    set_upd(15'h7, 20'h11111, 1);
    set_lkp(15'h7);
    #2;
    rst_n = 0;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    idle();
    m_clear();
    #2;
    rst_n = 1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 0;
    btb_en = 1;
    l0_en = 1;
    idle();
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;

    // Basic allocate then lookup.
    set_upd(15'h12, 20'hABCDE, 1);
    cyc(); idle();
    set_lkp(15'h12);
    cyc(); idle();
    chk("r37_hit", 32'(bus.lkp_hit), 1);
    chk("r37_tgt", 32'(bus.lkp_target), 32'hABCDE);
    chk("r37_tk", 32'(bus.lkp_taken), 1);
    chk("r37_vec", 32'(bus.entry_vld_vec), 32'h1);

    // Fill, then overflow into round-robin victims 0,1,2.
    do_reset();
    for (int i = 0; i < N + 3; i++) begin
      set_upd(15'(16'h100 + i), 20'(i * 7 + 1), 1);
      cyc();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      set_lkp(15'(16'h100 + i));
      cyc();
      if (i < 3) chk("r38_old_miss", 32'(bus.lkp_hit), 0);
      else       chk("r38_keep_hit", 32'(bus.lkp_hit), 1);
    end
    for (int i = 0; i < 3; i++) begin
      set_lkp(15'(16'h100 + N + i));
      cyc();
      chk("r38_new_hit", 32'(bus.lkp_hit), 1);
    end
    idle();

    // Counter decrements to 00; entry stays, target held.
    do_reset();
    set_upd(15'h30, 20'h12345, 1); cyc();
    set_upd(15'h30, 20'h0FFFF, 0); cyc();
    set_upd(15'h30, 20'h0EEEE, 0); cyc();
    idle(); set_lkp(15'h30); cyc(); idle();
    chk("r39_hit", 32'(bus.lkp_hit), 1);
    chk("r39_tk", 32'(bus.lkp_taken), 0);
    chk("r39_tgt", 32'(bus.lkp_target), 32'h12345);

    // inv beats a simultaneous update.
    set_upd(15'h44, 20'h44444, 1); cyc();
    bus.inv = 1; cyc(); idle();
    chk("r40_vec", 32'(bus.entry_vld_vec), 0);
    set_lkp(15'h44); cyc(); idle();
    chk("r40_miss", 32'(bus.lkp_hit), 0);

    // Disabled: everything ignored; re-enable restores hits.
    set_upd(15'h55, 20'h55555, 1); cyc(); idle();
    l0_en = 0;
    set_upd(15'h66, 20'h66666, 1); set_lkp(15'h55); cyc();
    chk("r41_off_miss", 32'(bus.lkp_hit), 0);
    chk("r41_vec", 32'(bus.entry_vld_vec), 32'h1);
    idle(); l0_en = 1;
    set_lkp(15'h55); cyc(); idle();
    chk("r41_on_hit", 32'(bus.lkp_hit), 1);

    // Lookup sees pre-write contents of a same-cycle allocation.
    set_upd(15'h5, 20'h00505, 1); set_lkp(15'h5); cyc();
    idle();
    chk("r42_same_miss", 32'(bus.lkp_hit), 0);
    set_lkp(15'h5); cyc(); idle();
    chk("r42_next_hit", 32'(bus.lkp_hit), 1);

    // Random traffic over a tag pool a bit larger than the array.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      btb_en = ($urandom_range(0, 15) != 0);
      l0_en  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 1) != 0)
        set_lkp(15'($urandom_range(0, 23)));
      if ($urandom_range(0, 1) != 0)
        set_upd(15'($urandom_range(0, 23)),
                20'($urandom()),
                ($urandom_range(0, 9) < 7));
      bus.inv = ($urandom_range(0, 59) == 0);
      cyc();
    end
    idle();
    btb_en = 1;
    l0_en = 1;

    // Reset in the middle of populated state.
    do_reset();
    set_lkp(15'h3); cyc(); idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ct_ifu_l0_btb_param_array.md
CT_IFU_L0_BTB_PARAM_ARRAY -- requirements
Module: ct_ifu_l0_btb_param_array

Interface
REQ-001 Parameter ENTRY_NUM, 16, number of entries; power of two, 4..64.
REQ-002 Parameter TAG_W, 15, tag width.
REQ-003 Parameter TGT_W, 20, target field width.
REQ-004 Parameter WAY_W, 2, way-prediction width.
REQ-005 forever_cpuclk  in  1  sole clock, rising edge.
REQ-006 cpurst_b  in  1  reset, asynchronous, active-low.
REQ-007 cp0_ifu_btb_en  in  1  global BTB enable.
REQ-008 cp0_ifu_l0btb_en  in  1  L0 BTB enable; block is active only when both enables are 1 (act).
REQ-009 lkp_vld  in  1  lookup request.
REQ-010 lkp_tag  in  TAG_W  lookup tag.
REQ-011 lkp_hit  out  1  registered hit result.
REQ-012 lkp_target  out  TGT_W  target of hit entry, 0 on miss.
REQ-013 lkp_way_pred  out  WAY_W  way prediction of hit entry, 0 on miss.
REQ-014 lkp_ras  out  1  hit entry is a return (use RAS), 0 on miss.
REQ-015 lkp_taken  out  1  counter MSB of hit entry, 0 on miss.
REQ-016 upd_vld  in  1  update request.
REQ-017 upd_tag / upd_target / upd_way_pred / upd_ras  in  TAG_W / TGT_W / WAY_W / 1  update payload.
REQ-018 upd_taken  in  1  resolved direction of the updated branch.
REQ-019 inv  in  1  invalidate all entries.
REQ-020 entry_vld_vec  out  ENTRY_NUM  per-entry valid bits.

Function
REQ-021 Each entry SHALL hold vld, tag[TAG_W], target[TGT_W], way_pred[WAY_W], ras, cnt[1:0] saturating counter.
REQ-022 Lookup SHALL have one-cycle latency: cycle N request (lkp_vld & act) compares against all valid entries; outputs registered and valid in cycle N+1.
REQ-023 No request or act=0 in cycle N: lkp_hit and all lkp_* data SHALL be 0 in N+1.
REQ-024 At most one entry SHALL match a tag; allocation never creates a duplicate tag.
REQ-025 Lookup in the same cycle as an update or inv SHALL see pre-write contents.
REQ-026 Update hit (upd_vld & act, tag matches a valid entry): cnt SHALL saturate-increment if upd_taken, else saturate-decrement; target/way_pred/ras overwritten only when upd_taken=1.
REQ-027 Update miss with upd_taken=1 SHALL allocate: lowest-index invalid entry; if none, entry rr_ptr, then rr_ptr increments modulo ENTRY_NUM (wraps to 0).
REQ-028 Allocated entry: vld=1, payload written, cnt=2'b10.
REQ-029 Update miss with upd_taken=0 SHALL change nothing.
REQ-030 rr_ptr (log2(ENTRY_NUM) bits) SHALL advance only on allocation into a valid victim.
REQ-031 inv SHALL clear all vld, tag, target, way_pred, ras, cnt and rr_ptr to 0 next edge; inv has priority over a simultaneous update, which is dropped.
REQ-032 inv SHALL take effect regardless of act; updates with act=0 SHALL be ignored and state held.
REQ-033 Entry storage SHALL be clock-gated per entry, enabled only on that entry's write or inv.
REQ-034 An entry with cnt=2'b00 SHALL remain valid (lkp_taken=0 on hit).

Reset
REQ-035 While cpurst_b=0 all entry fields, rr_ptr, lkp_hit, lkp_target, lkp_way_pred, lkp_ras, lkp_taken and entry_vld_vec SHALL be 0.
REQ-036 Reset asserted mid-lookup or mid-update SHALL abort it; first edge after release behaves as from empty.

Verification
REQ-037 Reset, upd tag=0x12 target=0xABCDE taken=1; next cycle lookup 0x12 -> following cycle lkp_hit=1, lkp_target=0xABCDE, lkp_taken=1, entry_vld_vec=0x0001.
REQ-038 Fill 16 distinct tags taken, then 3 more -> victims entries 0,1,2; rr_ptr=3; earliest three tags now miss.
REQ-039 Same tag updated taken=0 twice from cnt=10 -> cnt 01 then 00; lookup hits with lkp_taken=0, target unchanged.
REQ-040 inv and upd_vld same cycle -> entry_vld_vec=0 next cycle, lookup of update tag misses.
REQ-041 cp0_ifu_l0btb_en=0: updates and lookups -> lkp_hit=0, entry_vld_vec unchanged; re-enable -> prior entries hit.
REQ-042 Same-cycle update(tag=0x5 allocation) and lookup(0x5) -> lookup misses; lookup next cycle hits.
